// File: rtl/alu_issue_stage_if.sv
// Decode/forwarding bundle into the ID/EX issue stage and its registered ALU-side outputs.
// master = decode/pipeline side, slave = the issue stage.
interface alu_issue_stage_if;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          InValid;
  logic [DW-1:0] RsData;
  logic [DW-1:0] RtData;
  logic [RW-1:0] Rs;
  logic [RW-1:0] Rt;
  logic [RW-1:0] Rd;
  logic [15:0]   Imm16;
  logic [RW-1:0] Shamt;
  logic          SignExt;
  logic [1:0]    OpSel;
  logic [3:0]    ALUCtrlIn;
  logic          RegWrIn;
  logic          MemReadIn;
  logic          ExMemRegWr;
  logic          MemWbRegWr;
  logic [RW-1:0] ExMemRd;
  logic [RW-1:0] MemWbRd;
  logic [DW-1:0] ExMemResult;
  logic [DW-1:0] MemWbResult;
  logic          Stall;
  logic          Flush;
  logic [DW-1:0] BusA;
  logic [DW-1:0] BusB;
  logic [3:0]    ALUCtrl;
  logic          Valid;
  logic          RegWr;
  logic          MemRead;
  logic [RW-1:0] RdOut;
  logic          Hazard;

  modport master (
    output InValid, RsData, RtData, Rs, Rt, Rd, Imm16, Shamt, SignExt, OpSel,
           ALUCtrlIn, RegWrIn, MemReadIn, ExMemRegWr, MemWbRegWr, ExMemRd,
           MemWbRd, ExMemResult, MemWbResult, Stall, Flush,
    input  BusA, BusB, ALUCtrl, Valid, RegWr, MemRead, RdOut, Hazard
  );

  modport slave (
    input  InValid, RsData, RtData, Rs, Rt, Rd, Imm16, Shamt, SignExt, OpSel,
           ALUCtrlIn, RegWrIn, MemReadIn, ExMemRegWr, MemWbRegWr, ExMemRd,
           MemWbRd, ExMemResult, MemWbResult, Stall, Flush,
    output BusA, BusB, ALUCtrl, Valid, RegWr, MemRead, RdOut, Hazard
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: forwards and routes ALU operands, detects load-use hazards,
// and registers the operand bundle for the execute cycle.
module alu_issue_stage (
  input  logic           Clk,
  input  logic           Reset,
  alu_issue_stage_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic [DW-1:0] busa_q, busa_d;
  logic [DW-1:0] busb_q, busb_d;
  logic [3:0]    aluctrl_q, aluctrl_d;
  logic [RW-1:0] rd_q, rd_d;
  logic          valid_q, valid_d;
  logic          regwr_q, regwr_d;
  logic          memread_q, memread_d;

  logic [DW-1:0] rs_fwd, rt_fwd, ext_imm, op_a, op_b;
  logic          uses_rs, uses_rt, hazard;

  // EX/MEM beats MEM/WB; register 0 is never forwarded.
  function automatic logic [DW-1:0] fwd(
    input logic [RW-1:0] idx,
    input logic [DW-1:0] rf_data,
    input logic          exmem_wr,
    input logic [RW-1:0] exmem_rd,
    input logic [DW-1:0] exmem_res,
    input logic          memwb_wr,
    input logic [RW-1:0] memwb_rd,
    input logic [DW-1:0] memwb_res
  );
    if (exmem_wr && exmem_rd != '0 && exmem_rd == idx) return exmem_res;
    if (memwb_wr && memwb_rd != '0 && memwb_rd == idx) return memwb_res;
    return rf_data;
  endfunction

  always_comb begin
    rs_fwd  = fwd(bus.Rs, bus.RsData, bus.ExMemRegWr, bus.ExMemRd, bus.ExMemResult,
                  bus.MemWbRegWr, bus.MemWbRd, bus.MemWbResult);
    rt_fwd  = fwd(bus.Rt, bus.RtData, bus.ExMemRegWr, bus.ExMemRd, bus.ExMemResult,
                  bus.MemWbRegWr, bus.MemWbRd, bus.MemWbResult);
    ext_imm = bus.SignExt ? {{16{bus.Imm16[15]}}, bus.Imm16} : {16'b0, bus.Imm16};
    op_a    = rs_fwd;
    op_b    = rt_fwd;
    uses_rs = 1'b1;
    uses_rt = 1'b1;
    case (bus.OpSel)
      2'd0: begin op_a = rs_fwd; op_b = rt_fwd; end
      2'd1: begin op_a = rs_fwd; op_b = ext_imm; uses_rt = 1'b0; end
      2'd2: begin op_a = rt_fwd; op_b = {27'b0, bus.Shamt}; uses_rs = 1'b0; end
      default: begin op_a = rt_fwd; op_b = rs_fwd; end
    endcase
    hazard = bus.InValid & valid_q & memread_q & (rd_q != '0) &
             ((uses_rs & (rd_q == bus.Rs)) | (uses_rt & (rd_q == bus.Rt)));
  end

  // Flush > Stall > Hazard bubble > capture; bubbles and flushes keep the data registers.
  always_comb begin
    busa_d    = busa_q;
    busb_d    = busb_q;
    aluctrl_d = aluctrl_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    regwr_d   = regwr_q;
    memread_d = memread_q;
    if (bus.Flush || (!bus.Stall && hazard)) begin
      valid_d   = 1'b0;
      regwr_d   = 1'b0;
      memread_d = 1'b0;
    end else if (!bus.Stall) begin
      busa_d    = op_a;
      busb_d    = op_b;
      aluctrl_d = bus.ALUCtrlIn;
      rd_d      = bus.Rd;
      valid_d   = bus.InValid;
      regwr_d   = bus.RegWrIn & bus.InValid;
      memread_d = bus.MemReadIn & bus.InValid;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busa_q    <= '0;
      busb_q    <= '0;
      aluctrl_q <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      regwr_q   <= 1'b0;
      memread_q <= 1'b0;
    end else begin
      busa_q    <= busa_d;
      busb_q    <= busb_d;
      aluctrl_q <= aluctrl_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      regwr_q   <= regwr_d;
      memread_q <= memread_d;
    end
  end

  assign bus.BusA    = busa_q;
  assign bus.BusB    = busb_q;
  assign bus.ALUCtrl = aluctrl_q;
  assign bus.RdOut   = rd_q;
  assign bus.Valid   = valid_q;
  assign bus.RegWr   = regwr_q;
  assign bus.MemRead = memread_q;
  assign bus.Hazard  = hazard;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: stimulus queues expected registered outputs,
// a monitor pops and compares one entry after every rising edge.
module tb_alu_issue_stage;
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  alu_issue_stage_if bus ();
  alu_issue_stage dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
    logic [4:0]  rd;
    logic        v;
    logic        w;
    logic        m;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s.%s got=%h exp=%h", name, field, act, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] c, input logic [4:0] rd,
                              input logic v, input logic w, input logic m,
                              input string name);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.rd = rd; e.v = v; e.w = w; e.m = m; e.name = name;
    return e;
  endfunction

  // Monitor: registered outputs are compared just after each rising edge.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.name, "BusA",    bus.BusA, e.a);
      chk(e.name, "BusB",    bus.BusB, e.b);
      chk(e.name, "ALUCtrl", 32'(bus.ALUCtrl), 32'(e.c));
      chk(e.name, "RdOut",   32'(bus.RdOut), 32'(e.rd));
      chk(e.name, "Valid",   32'(bus.Valid), 32'(e.v));
      chk(e.name, "RegWr",   32'(bus.RegWr), 32'(e.w));
      chk(e.name, "MemRead", 32'(bus.MemRead), 32'(e.m));
    end
  end

  task automatic idle();
    Reset = 1'b0;
    bus.InValid = 1'b0; bus.RsData = '0; bus.RtData = '0;
    bus.Rs = '0; bus.Rt = '0; bus.Rd = '0; bus.Imm16 = '0; bus.Shamt = '0;
    bus.SignExt = 1'b0; bus.OpSel = '0; bus.ALUCtrlIn = '0;
    bus.RegWrIn = 1'b0; bus.MemReadIn = 1'b0;
    bus.ExMemRegWr = 1'b0; bus.MemWbRegWr = 1'b0;
    bus.ExMemRd = '0; bus.MemWbRd = '0; bus.ExMemResult = '0; bus.MemWbResult = '0;
    bus.Stall = 1'b0; bus.Flush = 1'b0;
  endtask

  // Inputs are set at a falling edge; check Hazard, queue the post-edge expectation.
  task automatic step(input exp_t e, input logic hz);
    #1;
    chk(e.name, "Hazard", 32'(bus.Hazard), 32'(hz));
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic instr(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [3:0] ctrl, input logic [4:0] rd);
    idle();
    bus.InValid = 1'b1; bus.OpSel = op; bus.Rs = rs; bus.Rt = rt;
    bus.RsData = rsd; bus.RtData = rtd; bus.ALUCtrlIn = ctrl; bus.Rd = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    Reset = 1'b1;
    @(negedge Clk);

    // Reset with random activity on the inputs
    for (int i = 0; i < 2; i++) begin
      idle();
      Reset = 1'b1;
      bus.InValid = 1'b1; bus.RegWrIn = 1'b1; bus.MemReadIn = 1'b1;
      bus.RsData = $urandom; bus.RtData = $urandom; bus.Rd = 5'($urandom);
      bus.ALUCtrlIn = 4'($urandom); bus.OpSel = 2'($urandom);
      step(mk(32'h0, 32'h0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, "reset"), 1'b0);
    end

    instr(2'd0, 5'd1, 5'd2, 32'd5, 32'd7, 4'd2, 5'd3); bus.RegWrIn = 1'b1;
    step(mk(32'd5, 32'd7, 4'd2, 5'd3, 1'b1, 1'b1, 1'b0, "first"), 1'b0);

    instr(2'd1, 5'd1, 5'd2, 32'd5, 32'd7, 4'd1, 5'd3);
    bus.Imm16 = 16'h8001; bus.SignExt = 1'b1;
    step(mk(32'd5, 32'hFFFF8001, 4'd1, 5'd3, 1'b1, 1'b0, 1'b0, "sext"), 1'b0);

    instr(2'd1, 5'd1, 5'd2, 32'd5, 32'd7, 4'd1, 5'd3);
    bus.Imm16 = 16'h8001; bus.SignExt = 1'b0;
    step(mk(32'd5, 32'h00008001, 4'd1, 5'd3, 1'b1, 1'b0, 1'b0, "zext"), 1'b0);

    instr(2'd2, 5'd1, 5'd2, 32'd9, 32'h12345678, 4'd3, 5'd4); bus.Shamt = 5'd2;
    step(mk(32'h12345678, 32'h2, 4'd3, 5'd4, 1'b1, 1'b0, 1'b0, "shamt"), 1'b0);

    instr(2'd3, 5'd1, 5'd2, 32'hA, 32'hB, 4'd4, 5'd5);
    step(mk(32'hB, 32'hA, 4'd4, 5'd5, 1'b1, 1'b0, 1'b0, "swap"), 1'b0);

    instr(2'd0, 5'd4, 5'd5, 32'd1, 32'd2, 4'd0, 5'd6);
    bus.ExMemRegWr = 1'b1; bus.ExMemRd = 5'd4; bus.ExMemResult = 32'hAAAA0000;
    bus.MemWbRegWr = 1'b1; bus.MemWbRd = 5'd4; bus.MemWbResult = 32'h5555;
    step(mk(32'hAAAA0000, 32'd2, 4'd0, 5'd6, 1'b1, 1'b0, 1'b0, "fwd_exmem"), 1'b0);

    instr(2'd0, 5'd4, 5'd4, 32'd1, 32'd2, 4'd0, 5'd6);
    bus.ExMemRegWr = 1'b0; bus.ExMemRd = 5'd4; bus.ExMemResult = 32'hAAAA0000;
    bus.MemWbRegWr = 1'b1; bus.MemWbRd = 5'd4; bus.MemWbResult = 32'h5555;
    step(mk(32'h5555, 32'h5555, 4'd0, 5'd6, 1'b1, 1'b0, 1'b0, "fwd_memwb"), 1'b0);

    instr(2'd0, 5'd0, 5'd0, 32'h77, 32'h88, 4'd0, 5'd6);
    bus.ExMemRegWr = 1'b1; bus.ExMemRd = 5'd0; bus.ExMemResult = 32'hAAAA0000;
    bus.MemWbRegWr = 1'b1; bus.MemWbRd = 5'd0; bus.MemWbResult = 32'h5555;
    step(mk(32'h77, 32'h88, 4'd0, 5'd6, 1'b1, 1'b0, 1'b0, "fwd_r0"), 1'b0);

    // Load followed by a dependent instruction: one bubble, then MEM/WB forward
    instr(2'd1, 5'd1, 5'd2, 32'h100, 32'h0, 4'd0, 5'd8);
    bus.Imm16 = 16'h0004; bus.SignExt = 1'b1; bus.RegWrIn = 1'b1; bus.MemReadIn = 1'b1;
    step(mk(32'h100, 32'h4, 4'd0, 5'd8, 1'b1, 1'b1, 1'b1, "load"), 1'b0);

    instr(2'd0, 5'd2, 5'd8, 32'h20, 32'h30, 4'd5, 5'd9); bus.RegWrIn = 1'b1;
    step(mk(32'h100, 32'h4, 4'd0, 5'd8, 1'b0, 1'b0, 1'b0, "bubble"), 1'b1);

    instr(2'd0, 5'd2, 5'd8, 32'h20, 32'h30, 4'd5, 5'd9); bus.RegWrIn = 1'b1;
    bus.MemWbRegWr = 1'b1; bus.MemWbRd = 5'd8; bus.MemWbResult = 32'hDEAD;
    step(mk(32'h20, 32'hDEAD, 4'd5, 5'd9, 1'b1, 1'b1, 1'b0, "after_bubble"), 1'b0);

    instr(2'd0, 5'd3, 5'd3, 32'd1, 32'd2, 4'd0, 5'd8);
    bus.RegWrIn = 1'b1; bus.MemReadIn = 1'b1;
    step(mk(32'd1, 32'd2, 4'd0, 5'd8, 1'b1, 1'b1, 1'b1, "load2"), 1'b0);

    instr(2'd1, 5'd2, 5'd8, 32'h40, 32'h0, 4'd6, 5'd10); bus.Imm16 = 16'h0010;
    step(mk(32'h40, 32'h10, 4'd6, 5'd10, 1'b1, 1'b0, 1'b0, "rt_unused"), 1'b0);

    // Stall freezes everything; flush overrides stall
    instr(2'd0, 5'd1, 5'd2, 32'h11, 32'h22, 4'd7, 5'd11); bus.RegWrIn = 1'b1;
    step(mk(32'h11, 32'h22, 4'd7, 5'd11, 1'b1, 1'b1, 1'b0, "pre_stall"), 1'b0);

    for (int i = 0; i < 3; i++) begin
      instr(2'd0, 5'd1, 5'd2, 32'h500 + 32'(i), 32'h600 + 32'(i), 4'd9, 5'd12);
      bus.MemReadIn = 1'b1; bus.Stall = 1'b1;
      step(mk(32'h11, 32'h22, 4'd7, 5'd11, 1'b1, 1'b1, 1'b0, "stall"), 1'b0);
    end

    instr(2'd0, 5'd1, 5'd2, 32'h700, 32'h800, 4'd9, 5'd12);
    bus.Stall = 1'b1; bus.Flush = 1'b1; bus.RegWrIn = 1'b1;
    step(mk(32'h11, 32'h22, 4'd7, 5'd11, 1'b0, 1'b0, 1'b0, "stall_flush"), 1'b0);

    instr(2'd0, 5'd1, 5'd2, 32'h99, 32'h98, 4'd1, 5'd13); bus.RegWrIn = 1'b1;
    step(mk(32'h99, 32'h98, 4'd1, 5'd13, 1'b1, 1'b1, 1'b0, "pre_reset"), 1'b0);

    instr(2'd0, 5'd1, 5'd2, 32'h55, 32'h66, 4'd2, 5'd14);
    Reset = 1'b1; bus.Stall = 1'b1;
    step(mk(32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, "mid_reset"), 1'b0);

    // Flush coinciding with a load-use hazard
    instr(2'd1, 5'd1, 5'd2, 32'h200, 32'h0, 4'd0, 5'd12);
    bus.Imm16 = 16'h0008; bus.RegWrIn = 1'b1; bus.MemReadIn = 1'b1;
    step(mk(32'h200, 32'h8, 4'd0, 5'd12, 1'b1, 1'b1, 1'b1, "load3"), 1'b0);

    instr(2'd0, 5'd1, 5'd12, 32'h1, 32'h2, 4'd3, 5'd15); bus.Flush = 1'b1;
    step(mk(32'h200, 32'h8, 4'd0, 5'd12, 1'b0, 1'b0, 1'b0, "flush_hazard"), 1'b1);

    instr(2'd0, 5'd1, 5'd2, 32'h3, 32'h4, 4'd8, 5'd16);
    bus.InValid = 1'b0; bus.RegWrIn = 1'b1; bus.MemReadIn = 1'b1;
    step(mk(32'h3, 32'h4, 4'd8, 5'd16, 1'b0, 1'b0, 1'b0, "invalid"), 1'b0);

    idle();
    @(posedge Clk);
    #3;
    chk("drain", "pending", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that sits directly upstream of the ALU and drives its BusA, BusB and ALUCtrl inputs. It selects operands from register-file data, an extended immediate or the shift amount, and forwards results from EX/MEM and MEM/WB. It detects load-use hazards, then registers the operand bundle for the execute cycle. Downstream stall and flush inputs let the pipeline freeze or squash the stage.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  decode presents an instruction this cycle.
- RsData, RtData  in  32  register-file read data.
- Rs, Rt, Rd  in  5  source/destination register indices.
- Imm16  in  16  instruction immediate.
- Shamt  in  5  instruction shift amount.
- SignExt  in  1  1 = sign-extend Imm16, 0 = zero-extend.
- OpSel  in  2  operand routing: 0 A=rs,B=rt; 1 A=rs,B=ext(imm); 2 A=rt,B={27'b0,Shamt}; 3 A=rt,B=rs.
- ALUCtrlIn  in  4  ALU operation code, passed through unchanged.
- RegWrIn, MemReadIn  in  1  instruction writes a register / is a load.
- ExMemRegWr, MemWbRegWr  in  1  older instructions write a register.
- ExMemRd, MemWbRd  in  5  their destinations.
- ExMemResult, MemWbResult  in  32  their result values.
- Stall  in  1  downstream hold.
- Flush  in  1  squash stage contents.
- BusA, BusB  out  32  registered ALU operands.
- ALUCtrl  out  4  registered ALU control.
- Valid, RegWr, MemRead  out  1  registered stage status and controls.
- RdOut  out  5  registered destination.
- Hazard  out  1  combinational load-use stall request to decode.

## Operation
- **Forwarding.** Forwarding is applied per source (rs, rt) to the data before operand routing.
  - If ExMemRegWr and ExMemRd != 0 and ExMemRd == index, use ExMemResult.
  - Otherwise, if MemWbRegWr and MemWbRd != 0 and MemWbRd == index, use MemWbResult.
  - Otherwise use the register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- **Immediate extension.** ext(imm) = {{16{Imm16[15]}},Imm16} when SignExt=1, else {16'b0,Imm16}.
- **Source usage.** Rs is used by OpSel 0, 1 and 3. Rt is used by OpSel 0, 2 and 3.
- **Hazard.** Hazard = InValid & Valid & MemRead & RdOut != 0 & ((uses rs & RdOut == Rs) | (uses rt & RdOut == Rt)).
- **Update priority each cycle:**
  - Reset: clear all outputs.
  - Else Flush: Valid, RegWr and MemRead go to 0; data registers are don't-care and are held.
  - Else Stall: hold every register; Flush is ignored while held only if Flush=0.
  - Else Hazard: insert a bubble; Valid, RegWr and MemRead go to 0. Decode holds its instruction.
  - Else capture: load the forwarded and routed operands, ALUCtrlIn, Rd, and Valid=InValid. RegWr = RegWrIn & InValid, and MemRead = MemReadIn & InValid.
- **Invalid controls.** When Valid=0, RegWr and MemRead are always 0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- **Reset values:** BusA=0, BusB=0, ALUCtrl=0, RdOut=0, Valid=0, RegWr=0, MemRead=0. Hazard therefore reads 0 after reset.
- **Simultaneous events:**
  - Flush together with Stall: flush wins.
  - Flush together with Hazard: flush wins, and Hazard still asserts combinationally that cycle.
- **Reset mid-operation:** Reset in any cycle clears the stage at the next edge regardless of Stall or Flush; no partial state survives.
- **Load-use bubble:** lasts exactly one cycle. The next cycle RdOut belongs to the bubble (Valid=0), so Hazard drops and decode issues. The load's result then arrives through the MEM/WB forward.

## Test plan
- **Reset:** Reset=1 for 2 cycles with random inputs -> all outputs 0. Release, InValid=1, OpSel=0, RsData=5, RtData=7, ALUCtrlIn=2 -> next cycle BusA=5, BusB=7, ALUCtrl=2, Valid=1.
- **Immediate and shift routing:**
  - OpSel=1, Imm16=0x8001, SignExt=1 -> BusB=0xFFFF8001. With SignExt=0 -> BusB=0x00008001.
  - OpSel=2, RtData=0x12345678, Shamt=2, ALUCtrlIn=3 -> BusA=0x12345678, BusB=0x00000002.
- **Forward priority:** Rs=4, ExMemRd=4 (0xAAAA0000), MemWbRd=4 (0x5555) both writing -> BusA=0xAAAA0000.
  - Drop ExMemRegWr -> BusA=0x00005555.
  - With Rs=0 and both forwards targeting 0 -> BusA=RsData.
- **Load-use:** capture a load with RegWrIn=1, MemReadIn=1, Rd=8, then present Rt=8 with OpSel=0 -> Hazard=1, next cycle Valid=0, RegWr=0. Following cycle Hazard=0 and the instruction captures with the MemWbResult forward. With OpSel=1 (rt unused) -> Hazard=0.
- **Stall/flush:** capture BusA=0x11, then Stall=1 for 3 cycles with changing inputs -> outputs frozen at 0x11. Flush=1 with Stall=1 -> Valid=0, RegWr=0 next cycle.
